// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// Merges ALU (port A) and mult/div (port B) writebacks onto the single
// register file write port. Port B requests are buffered in a small
// circular FIFO. Port A has priority over port B.
// Optional feature macro: WB_STARVE_GUARD_EN. When it is defined, port B
// gets a forced grant after its head entry has waited STARVE_LIMIT cycles.
// When it is undefined, port A always has priority and a_ready is tied high.

module writeback_arbiter #(
    parameter int B_DEPTH      = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clock,
    input  logic                       ctrl_reset_n,

    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [4:0]                 a_reg,
    input  logic [31:0]                a_data,

    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [4:0]                 b_reg,
    input  logic [31:0]                b_data,

    output logic                       ctrl_writeEnable,
    output logic [4:0]                 ctrl_writeReg,
    output logic [31:0]                data_writeReg,

    output logic [$clog2(B_DEPTH):0]   b_count
);

    localparam int PTR_W = $clog2(B_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(B_DEPTH);

    // Reject configurations the pointer arithmetic and the 4-bit starve counter cannot handle
    generate
        if ((B_DEPTH < 2) || ((B_DEPTH & (B_DEPTH - 1)) != 0)) begin : gBadDepth
            $error("writeback_arbiter: B_DEPTH must be a power of 2 and at least 2");
        end
        if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : gBadLimit
            $error("writeback_arbiter: STARVE_LIMIT must be in 1..15");
        end
    endgenerate

    // FIFO storage and bookkeeping
    logic [4:0]       fifoReg_q  [B_DEPTH];
    logic [31:0]      fifoData_q [B_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Output register state
    logic             writeEnable_q, writeEnable_d;
    logic [4:0]       writeReg_q,    writeReg_d;
    logic [31:0]      writeData_q,   writeData_d;

    // Handshake and arbitration
    logic             fifoNotEmpty;
    logic             fifoPush;
    logic             fifoPop;
    logic             grantA;
    logic             grantB;

    assign fifoNotEmpty = (count_q != '0);
    assign b_ready      = (count_q != FULL_COUNT);

    // Register 0 is hard-wired zero, so such B requests are handshaken but never stored
    assign fifoPush = b_valid && b_ready && (b_reg != 5'd0);

    assign grantA  = a_valid && a_ready;
    assign grantB  = fifoNotEmpty && !grantA;
    assign fifoPop = grantB;

`ifdef WB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    logic       forceB;

    assign forceB  = (starve_q == LIMIT);
    assign a_ready = !forceB;

    // Starve counter: counts cycles the B head waits, saturating at the limit
    always_comb begin
        starve_d = starve_q;
        if (!fifoNotEmpty || grantB) begin
            starve_d = 4'd0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Starve counter register
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign a_ready = 1'b1;
`endif

    // FIFO pointer and occupancy next-state; pointers wrap naturally at the power-of-2 depth
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (fifoPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (fifoPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({fifoPush, fifoPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset is needed
    always_ff @(posedge clock) begin
        if (fifoPush) begin
            fifoReg_q[wrPtr_q]  <= b_reg;
            fifoData_q[wrPtr_q] <= b_data;
        end
    end

    // Select what the write port does next cycle; index and data hold when idle
    always_comb begin
        writeEnable_d = 1'b0;
        writeReg_d    = writeReg_q;
        writeData_d   = writeData_q;
        if (grantA) begin
            if (a_reg != 5'd0) begin
                writeEnable_d = 1'b1;
                writeReg_d    = a_reg;
                writeData_d   = a_data;
            end
        end else if (grantB) begin
            writeEnable_d = 1'b1;
            writeReg_d    = fifoReg_q[rdPtr_q];
            writeData_d   = fifoData_q[rdPtr_q];
        end
    end

    // Registered write port toward the register file
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            writeEnable_q <= 1'b0;
            writeReg_q    <= 5'd0;
            writeData_q   <= 32'd0;
        end else begin
            writeEnable_q <= writeEnable_d;
            writeReg_q    <= writeReg_d;
            writeData_q   <= writeData_d;
        end
    end

    assign ctrl_writeEnable = writeEnable_q;
    assign ctrl_writeReg    = writeReg_q;
    assign data_writeReg    = writeData_q;
    assign b_count          = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter
// Directed bench for writeback_arbiter. Inputs change and outputs are sampled
// 1 time unit after each rising clock edge. The starvation scenario expects
// the behaviour matching whether WB_STARVE_GUARD_EN is defined.

module tb_writeback_arbiter;

    logic        clock;
    logic        ctrl_reset_n;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [2:0]  b_count;

    int checkCount;
    int passCount;

    writeback_arbiter #(
        .B_DEPTH      (4),
        .STARVE_LIMIT (4)
    ) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .a_valid          (a_valid),
        .a_ready          (a_ready),
        .a_reg            (a_reg),
        .a_data           (a_data),
        .b_valid          (b_valid),
        .b_ready          (b_ready),
        .b_reg            (b_reg),
        .b_data           (b_data),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .b_count          (b_count)
    );

    // Free-running clock, period 10
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Count one comparison and report it if it differs
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive both request ports
    task automatic applyStimulus(input logic aV, input logic [4:0] aR, input logic [31:0] aD,
                                 input logic bV, input logic [4:0] bR, input logic [31:0] bD);
        a_valid = aV;
        a_reg   = aR;
        a_data  = aD;
        b_valid = bV;
        b_reg   = bR;
        b_data  = bD;
    endtask

    // Advance to just after the next rising edge
    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    // Check the full write port state
    task automatic checkWrite(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
        checkOutput({tag, ".we"},   {31'd0, ctrl_writeEnable}, {31'd0, we});
        checkOutput({tag, ".reg"},  {27'd0, ctrl_writeReg},    {27'd0, r});
        checkOutput({tag, ".data"}, data_writeReg,             d);
    endtask

    // Main directed sequence
    initial begin
        checkCount   = 0;
        passCount    = 0;
        ctrl_reset_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        #3;
        checkWrite("reset", 1'b0, 5'd0, 32'd0);
        checkOutput("reset.b_count", {29'd0, b_count}, 32'd0);
        checkOutput("reset.b_ready", {31'd0, b_ready}, 32'd1);
        checkOutput("reset.a_ready", {31'd0, a_ready}, 32'd1);

        @(negedge clock);
        ctrl_reset_n = 1'b1;
        stepCycle();
        checkWrite("release", 1'b0, 5'd0, 32'd0);

        // Single A write, one cycle latency, then idle hold
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkWrite("aWrite", 1'b1, 5'd5, 32'hDEADBEEF);
        stepCycle();
        checkWrite("aIdle", 1'b0, 5'd5, 32'hDEADBEEF);

        // A to register 0 is consumed without a write
        applyStimulus(1'b1, 5'd0, 32'h00000123, 1'b0, 5'd0, 32'd0);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkWrite("aZero", 1'b0, 5'd5, 32'hDEADBEEF);

        // B to register 0 is accepted but never queued
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h00000055);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("bZero.count", {29'd0, b_count}, 32'd0);
        stepCycle();
        checkWrite("bZero", 1'b0, 5'd5, 32'hDEADBEEF);

        // Streamed B burst with A idle: writes start two edges after first accept
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) begin
                applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'h100 + i);
                checkOutput($sformatf("stream%0d.b_ready", i), {31'd0, b_ready}, 32'd1);
            end else begin
                applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            end
            stepCycle();
            if (i == 1) begin
                checkWrite("stream1", 1'b0, 5'd5, 32'hDEADBEEF);
                checkOutput("stream1.count", {29'd0, b_count}, 32'd1);
            end else begin
                checkWrite($sformatf("stream%0d", i), 1'b1, 5'(i - 1), 32'h100 + i - 1);
                checkOutput($sformatf("stream%0d.count", i), {29'd0, b_count}, (i == 5) ? 32'd0 : 32'd1);
            end
        end
        stepCycle();
        checkWrite("streamEnd", 1'b0, 5'd4, 32'h104);

        // Fill the FIFO while A keeps the port busy with register-0 requests
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 5'd0, 32'd0, 1'b1, 5'(8 + i), 32'h200 + i);
            stepCycle();
            checkOutput($sformatf("fill%0d.we", i), {31'd0, ctrl_writeEnable}, 32'd0);
            checkOutput($sformatf("fill%0d.count", i), {29'd0, b_count}, 32'(i));
            checkOutput($sformatf("fill%0d.b_ready", i), {31'd0, b_ready}, (i == 4) ? 32'd0 : 32'd1);
        end

        // Full: an offered B entry must be refused even though a pop happens this cycle
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 32'h00000BAD);
        checkOutput("fullPop.b_ready", {31'd0, b_ready}, 32'd0);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            checkWrite($sformatf("drain%0d", i), 1'b1, 5'(8 + i), 32'h200 + i);
            checkOutput($sformatf("drain%0d.count", i), {29'd0, b_count}, 32'(4 - i));
            stepCycle();
        end
        checkWrite("drainEnd", 1'b0, 5'd12, 32'h204);

        // One B entry queued behind continuous A traffic
        applyStimulus(1'b1, 5'd20, 32'hA00, 1'b1, 5'd7, 32'h777);
`ifdef WB_STARVE_GUARD_EN
        for (int k = 0; k <= 6; k++) begin
            stepCycle();
            if (k < 5) begin
                checkWrite($sformatf("starve%0d", k), 1'b1, 5'(20 + k), 32'hA00 + k);
            end else if (k == 5) begin
                checkWrite("starveB", 1'b1, 5'd7, 32'h777);
            end else begin
                checkWrite("starveResume", 1'b1, 5'd25, 32'hA05);
            end
            checkOutput($sformatf("starve%0d.a_ready", k), {31'd0, a_ready}, (k == 4) ? 32'd0 : 32'd1);
            if (k < 4) begin
                applyStimulus(1'b1, 5'(21 + k), 32'hA01 + k, 1'b0, 5'd0, 32'd0);
            end else if (k < 6) begin
                applyStimulus(1'b1, 5'd25, 32'hA05, 1'b0, 5'd0, 32'd0);
            end else begin
                applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            end
        end
        stepCycle();
        checkWrite("starveEnd", 1'b0, 5'd25, 32'hA05);
        checkOutput("starveEnd.count", {29'd0, b_count}, 32'd0);
`else
        for (int k = 0; k <= 6; k++) begin
            stepCycle();
            checkWrite($sformatf("strict%0d", k), 1'b1, 5'(20 + k), 32'hA00 + k);
            checkOutput($sformatf("strict%0d.a_ready", k), {31'd0, a_ready}, 32'd1);
            checkOutput($sformatf("strict%0d.count", k), {29'd0, b_count}, 32'd1);
            if (k < 6) begin
                applyStimulus(1'b1, 5'(21 + k), 32'hA01 + k, 1'b0, 5'd0, 32'd0);
            end else begin
                applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            end
        end
        stepCycle();
        checkWrite("strictB", 1'b1, 5'd7, 32'h777);
        stepCycle();
        checkWrite("strictEnd", 1'b0, 5'd7, 32'h777);
        checkOutput("strictEnd.count", {29'd0, b_count}, 32'd0);
`endif

        // Queue three B entries with a real A write in flight, then reset mid-cycle
        applyStimulus(1'b1, 5'd0, 32'd0, 1'b1, 5'd1, 32'h301);
        stepCycle();
        applyStimulus(1'b1, 5'd0, 32'd0, 1'b1, 5'd2, 32'h302);
        stepCycle();
        applyStimulus(1'b1, 5'd30, 32'hCAFE, 1'b1, 5'd3, 32'h303);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkWrite("preReset", 1'b1, 5'd30, 32'hCAFE);
        checkOutput("preReset.count", {29'd0, b_count}, 32'd3);
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        checkWrite("midReset", 1'b0, 5'd0, 32'd0);
        checkOutput("midReset.count", {29'd0, b_count}, 32'd0);
        checkOutput("midReset.b_ready", {31'd0, b_ready}, 32'd1);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        stepCycle();
        checkWrite("postReset1", 1'b0, 5'd0, 32'd0);
        checkOutput("postReset1.count", {29'd0, b_count}, 32'd0);
        stepCycle();
        checkWrite("postReset2", 1'b0, 5'd0, 32'd0);

        // Normal A traffic resumes after reset
        applyStimulus(1'b1, 5'd9, 32'h12345678, 1'b0, 5'd0, 32'd0);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkWrite("postResetA", 1'b1, 5'd9, 32'h12345678);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Write-side initiator for the 32x32 register file. It collects writeback requests from two producers: the single-cycle ALU (port A) and the multi-cycle mult/div unit (port B). It serializes them onto the register file's single write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg). Port B requests are buffered in a small FIFO, and an optional starvation guard keeps B from waiting forever behind A.

## Interface
- B_DEPTH, 4: port-B FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 4: cycles B head may wait before forced grant; range 1..15, 4-bit counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- ctrl_reset_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  ALU writeback request.
- a_ready  out  1  ALU request accepted this cycle when a_valid is also high.
- a_reg  in  5  ALU destination register.
- a_data  in  32  ALU result.
- b_valid  in  1  mult/div writeback request.
- b_ready  out  1  FIFO can accept (not full).
- b_reg  in  5  mult/div destination register.
- b_data  in  32  mult/div result.
- ctrl_writeEnable  out  1  register file write enable (registered).
- ctrl_writeReg  out  5  register file write index (registered).
- data_writeReg  out  32  register file write data (registered).
- b_count  out  log2(B_DEPTH)+1  current FIFO occupancy.

## Operation
- Reset (asynchronous assert, synchronous release):
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
  - FIFO empty, b_count=0, b_ready=1, starve counter=0.
  - a_ready=1.
- B enqueue:
  - Occurs when b_valid && b_ready.
  - A request with b_reg==0 is accepted and discarded; it is not pushed and b_count is unchanged.
- Arbitration, evaluated each cycle:
  - grant_A = a_valid && a_ready.
  - grant_B = FIFO non-empty && !grant_A.
  - Exactly zero or one grant per cycle.
- a_ready = !force_B. With the guard compiled out, a_ready is constantly 1.
- Output register on each edge:
  - On grant_A with a_reg!=0: ctrl_writeEnable=1, ctrl_writeReg=a_reg, data_writeReg=a_data.
  - On grant_A with a_reg==0: the request is consumed and ctrl_writeEnable=0.
  - On grant_B: the FIFO head is popped, ctrl_writeEnable=1, ctrl_writeReg and data_writeReg take the head values.
  - With no grant: ctrl_writeEnable=0, and ctrl_writeReg and data_writeReg hold their previous values.
- FIFO:
  - Circular buffer with wrap-around read and write pointers.
  - b_ready = (b_count != B_DEPTH).
  - Push and pop in the same cycle is legal when not full; b_count is unchanged.
  - When full, b_ready=0, including in a cycle where a pop occurs.
  - There is no bypass: a B entry always spends at least one cycle in the FIFO.
- Ordering:
  - B entries issue in FIFO order.
  - A and B targeting the same register are written in grant order. The later grant wins in the register file.

## Timing
- Port A: accepted at edge N -> write port asserted during cycle N+1 -> register file commits at edge N+1.
  - Latency 1 cycle.
  - Back-to-back A every cycle sustains 1 write per cycle.
- Port B, earliest case: accepted at edge N -> head visible in cycle N+1 -> granted if A is idle -> write port asserted in cycle N+2 -> committed at edge N+2.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and grant_B=0; saturates at STARVE_LIMIT.
  - Clears on grant_B or when the FIFO is empty.
  - force_B = (counter == STARVE_LIMIT), combinational. It drops a_ready that cycle, so B is granted.
- Reset asserted mid-operation:
  - Outputs go to 0 immediately (asynchronous).
  - FIFO contents are lost, and no write is issued on the first edge after release.
- The FIFO pointer wrap at B_DEPTH is seamless; no bubble cycle.

## Configuration
- WB_STARVE_GUARD_EN defined:
  - Starve counter and force_B are present, as described above.
  - Worst-case B head wait is STARVE_LIMIT cycles under continuous A traffic.
- WB_STARVE_GUARD_EN undefined:
  - Strict A priority, a_ready tied to 1, no counter logic.
  - Under continuous A traffic, B can starve indefinitely.

## Test plan
- Reset and release, then A request reg 5 / 0xDEADBEEF at edge N -> cycle N+1: ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF; cycle N+2: ctrl_writeEnable=0.
- Zero-register drop:
  - A with reg 0 -> no write enable.
  - B with reg 0 -> b_count stays 0 and no write enable.
- Fill FIFO with 4 B entries (regs 1..4) while A is idle -> all four written in order, one per cycle starting 2 cycles after the first accept. b_ready=0 only when b_count=4. Pointers wrap cleanly on a second burst of 4.
- With guard enabled, STARVE_LIMIT=4, continuous A valid and one B entry queued -> a_ready drops for exactly one cycle after 4 waiting cycles, the B write issues, and A resumes.
- Same stimulus with guard compiled out -> a_ready stays 1 and B is not written until A goes idle.
- Assert ctrl_reset_n low with 3 B entries queued and a write in flight -> outputs 0 immediately, b_count=0. After release, no spurious write enable.
